// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//
// MIPS-style instruction-decode stage. It contains the register file, the
// rs/rt operand forwarding, the load-use hazard check, branch and jump
// resolution with a one-cycle squash of the wrong-path instruction, the
// ID/EX pipeline register and a RUN/DRAIN/HALTED halt sequencer.
//
// Ports
//   clock_i, reset_i        clock (rising edge) and async active-low reset
//   enable_i                pipeline advance enable; 0 freezes all state
//   instr_valid_i           instruction_i / pc_i carry a real instruction
//   instruction_i, pc_i     instruction in ID and its PC+4
//   wb_write_i/reg/data     register-file write port from write-back
//   ex_*                    EX-stage write flag, load flag, dest, ALU result
//   mem_*                   MEM-stage write flag, dest, result
//   dbg_addr_i, dbg_data_o  debug register read (no bypass)
//   stall_o                 hold PC and IF/ID
//   pc_redirect_o/target_o  taken branch or jump and its target
//   idex_*                  registered ID/EX payload
//   halted_o                processor halted
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int HALT_DRAIN = 3
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               instr_valid_i,
  input  logic [31:0]        instruction_i,
  input  logic [NB_DATA-1:0] pc_i,
  input  logic               wb_write_i,
  input  logic [NB_REG-1:0]  wb_reg_i,
  input  logic [NB_DATA-1:0] wb_data_i,
  input  logic               ex_reg_write_i,
  input  logic               ex_mem_read_i,
  input  logic [NB_REG-1:0]  ex_rd_i,
  input  logic [NB_DATA-1:0] ex_result_i,
  input  logic               mem_reg_write_i,
  input  logic [NB_REG-1:0]  mem_rd_i,
  input  logic [NB_DATA-1:0] mem_result_i,
  input  logic [NB_REG-1:0]  dbg_addr_i,
  output logic [NB_DATA-1:0] dbg_data_o,
  output logic               stall_o,
  output logic               pc_redirect_o,
  output logic [NB_DATA-1:0] pc_target_o,
  output logic               idex_valid_o,
  output logic [31:0]        idex_instr_o,
  output logic [NB_DATA-1:0] idex_ra_o,
  output logic [NB_DATA-1:0] idex_rb_o,
  output logic [NB_DATA-1:0] idex_imm_o,
  output logic [NB_DATA-1:0] idex_pc_o,
  output logic               halted_o
);

  localparam int N_REGS = 1 << NB_REG;
  localparam int CNT_W  = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALT_DRAIN - 1);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_HALT    = 6'b111111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               squash_q;
  logic [NB_DATA-1:0] regs [N_REGS];

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [NB_REG-1:0]  rs_addr;
  logic [NB_REG-1:0]  rt_addr;
  logic [NB_DATA-1:0] imm_ext;

  assign opcode  = instruction_i[31:26];
  assign funct   = instruction_i[5:0];
  assign rs_addr = NB_REG'(instruction_i[25:21]);
  assign rt_addr = NB_REG'(instruction_i[20:16]);
  assign imm_ext = {{(NB_DATA-16){instruction_i[15]}}, instruction_i[15:0]};

  // -------------------------------------------------------------------------
  // Register file. Register 0 is never written, so it always reads zero.
  // -------------------------------------------------------------------------
  // NOTE: the register array is reset explicitly because software relies on
  // every register reading zero after reset; this costs flops rather than RAM.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (enable_i && wb_write_i && (wb_reg_i != '0)) begin
      regs[wb_reg_i] <= wb_data_i;
    end
  end

  assign dbg_data_o = regs[dbg_addr_i];

  // Operand selection, youngest producer first: EX ALU result (loads are not
  // ready yet), then MEM, then the write-back value, then the stored register.
  function automatic logic [NB_DATA-1:0] operand(input logic [NB_REG-1:0]  addr,
                                                 input logic [NB_DATA-1:0] rf_val);
    if (addr == '0)
      return '0;
    else if (ex_reg_write_i && !ex_mem_read_i && (ex_rd_i == addr))
      return ex_result_i;
    else if (mem_reg_write_i && (mem_rd_i == addr))
      return mem_result_i;
    else if (wb_write_i && (wb_reg_i == addr))
      return wb_data_i;
    else
      return rf_val;
  endfunction

  logic [NB_DATA-1:0] op_a;
  logic [NB_DATA-1:0] op_b;

  assign op_a = operand(rs_addr, regs[rs_addr]);
  assign op_b = operand(rt_addr, regs[rt_addr]);

  // -------------------------------------------------------------------------
  // Hazards and control decode
  // -------------------------------------------------------------------------
  logic live;       // a real instruction that is not the squashed wrong path
  logic load_use;
  logic is_halt;
  logic running;
  logic taken;
  logic [NB_DATA-1:0] target;
  logic idex_valid_d;

  assign live     = instr_valid_i & ~squash_q;
  assign load_use = live & ex_mem_read_i & (ex_rd_i != '0) &
                    ((ex_rd_i == rs_addr) | (ex_rd_i == rt_addr));
  assign is_halt  = live & (opcode == OP_HALT);
  assign running  = (state_q == ST_RUN);

  // NOTE: every signal written in an always_comb gets a default on entry so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    taken  = 1'b0;
    target = pc_i + (imm_ext << 2);
    unique case (opcode)
      OP_BEQ:      taken = (op_a == op_b);
      OP_BNE:      taken = (op_a != op_b);
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = {pc_i[NB_DATA-1:28], instruction_i[25:0], 2'b00};
      end
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) begin
          taken  = 1'b1;
          target = op_a;
        end
      end
      default: ;
    endcase
  end

  assign pc_target_o   = target;
  assign pc_redirect_o = taken & live & ~load_use & running & enable_i;
  assign stall_o       = ~enable_i | ~running | load_use;
  assign idex_valid_d  = live & ~load_use & running & ~is_halt;
  assign halted_o      = (state_q == ST_HALTED);

  // -------------------------------------------------------------------------
  // Halt sequencer
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (is_halt && !load_use) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HALTED: ;
      default:   state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      squash_q <= 1'b0;
    end else if (enable_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // The instruction fetched behind a taken branch is on the wrong path.
      squash_q <= pc_redirect_o;
    end
  end

  // -------------------------------------------------------------------------
  // ID/EX register: bubbles carry an all-zero payload.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      idex_valid_o <= 1'b0;
      idex_instr_o <= '0;
      idex_ra_o    <= '0;
      idex_rb_o    <= '0;
      idex_imm_o   <= '0;
      idex_pc_o    <= '0;
    end else if (enable_i) begin
      idex_valid_o <= idex_valid_d;
      if (idex_valid_d) begin
        idex_instr_o <= instruction_i;
        idex_ra_o    <= op_a;
        idex_rb_o    <= op_b;
        idex_imm_o   <= imm_ext;
        idex_pc_o    <= pc_i;
      end else begin
        idex_instr_o <= '0;
        idex_ra_o    <= '0;
        idex_rb_o    <= '0;
        idex_imm_o   <= '0;
        idex_pc_o    <= '0;
      end
    end
  end

endmodule
